forward_unit_gen: RTL and testbench
===================================

FORWARD_UNIT_GEN -- requirements
Module: forward_unit_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter NSRC, default 2, meaning number of source operands per instruction.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the stall counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have ports:
 Clk  in  1  rising-edge clock
 Rst  in  1  synchronous active-high reset
 IdValid  in  1  valid instruction present in ID
 IdRs  in  NSRC*ADDR_W  ID source registers; operand k at bits [k*ADDR_W +: ADDR_W]
 IdRd  in  ADDR_W  ID destination register
 IdRegWrite  in  1  ID instruction writes Rd
 IdMemRead  in  1  ID instruction is a load
 MemWait  in  1  data-memory wait; whole pipeline frozen
 Flush  in  1  taken branch/jump; squash ID instruction
 Forward  out  2*NSRC  per-operand select for the EX instruction; operand k at bits [2k+1:2k]
 Stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
 StallCount  out  CNT_W  saturating count of load-use stall cycles

Function
REQ-006 The block SHALL keep internal stage registers IDEX {Valid, Rs[NSRC], Rd, RegWrite, MemRead}, EXMEM {Valid, Rd, RegWrite} and MEMWB {Valid, Rd, RegWrite}.
REQ-007 Each rising edge with MemWait=0 SHALL advance the stages: MEMWB<=EXMEM, EXMEM<=IDEX, and IDEX<=ID inputs, with Valid=IdValid.
REQ-008 When Stall=1 or Flush=1, IDEX SHALL instead load a bubble: Valid=0, RegWrite=0, MemRead=0.
REQ-009 With MemWait=1, all stage registers and StallCount SHALL hold their values; Forward and Stall SHALL still be evaluated from the held state.
REQ-010 A stage SHALL be a forwarding producer only if Valid=1, RegWrite=1 and Rd!=0.
REQ-011 For each operand k, Forward[2k+1:2k] SHALL be 01 if the EXMEM stage produces for IDEX.Rs[k].
REQ-012 Otherwise Forward[2k+1:2k] SHALL be 10 if the MEMWB stage produces for IDEX.Rs[k].
REQ-013 Otherwise Forward[2k+1:2k] SHALL be 00.
REQ-014 When both EXMEM and MEMWB match, EXMEM SHALL win (01); encoding 11 SHALL never be driven.
REQ-015 Forward bits of operand k SHALL be 00 when IDEX.Valid=0.
REQ-016 Forward SHALL be combinational from stage registers only, with zero cycles of latency relative to the EX stage.
REQ-017 Load-use hazard SHALL be asserted when IdValid=1, IDEX.Valid=1, IDEX.MemRead=1, IDEX.RegWrite=1, IDEX.Rd!=0, and any IdRs[k]==IDEX.Rd.
REQ-018 Stall SHALL equal hazard AND NOT Flush; Flush has priority over Stall.
REQ-019 A stall SHALL last exactly one cycle per load: the bubble removes the hazard on the next cycle, and the dependent instruction then receives Forward=10 in EX.
REQ-020 Back-to-back loads feeding a dependent SHALL stall only against the load in IDEX.
REQ-021 StallCount SHALL increment by 1 on each edge where Stall=1 and MemWait=0.
REQ-022 StallCount SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 Rd=0 SHALL never produce forwarding or a stall.

Reset
REQ-024 With Rst=1 at an edge, all stage Valid/RegWrite/MemRead SHALL clear to 0, Rd/Rs SHALL clear to 0, and StallCount SHALL clear to 0; Rst SHALL override MemWait and Flush.
REQ-025 After reset, Forward SHALL be all zeros and Stall SHALL be 0.
REQ-026 Rst asserted mid-stall SHALL drop Stall to 0 on the following cycle.

Verification
REQ-027 Issue ADD x5 then SUB using x5 (rs1) -> SUB in EX sees Forward[1:0]=01, Stall=0.
REQ-028 Issue ADD x5, NOP, then OR using x5 (rs2) -> OR in EX sees Forward[3:2]=10; with ADD x5 then ADD x5 then use, the result is 01 (EXMEM priority).
REQ-029 Issue LW x7 then AND using x7 -> Stall=1 for exactly one cycle, bubble in IDEX, AND in EX sees 10, StallCount=1.
REQ-030 Issue LW x7 with a dependent in ID and Flush=1 the same cycle -> Stall=0, IDEX bubble, StallCount unchanged.
REQ-031 Hold MemWait=1 for 3 cycles during an EXMEM-match -> Forward stays 01 for all 3 cycles and stages do not move.
REQ-032 Issue writes to x0 before and after a load to x0 -> Forward=00 and Stall=0 throughout; set CNT_W=2 and force 5 stalls -> StallCount=3.

Source files
------------

// File: rtl/forward_unit_gen.sv
// Forwarding and load-use hazard unit for an in-order ID/EX/MEM/WB pipeline.
// Mirrors the destination side of IDEX/EXMEM/MEMWB and drives operand forward selects.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   IdValid           instruction present in ID
//   IdRs              ID source registers, operand k at [k*ADDR_W +: ADDR_W]
//   IdRd              ID destination register
//   IdRegWrite        ID instruction writes Rd
//   IdMemRead         ID instruction is a load
//   MemWait           data-memory wait, whole pipeline frozen
//   Flush             squash the ID instruction (taken branch/jump)
//   Forward           per-operand select for EX: 00 reg file, 01 EXMEM, 10 MEMWB
//   Stall             hold PC and IF/ID, insert bubble into IDEX
//   StallCount        saturating count of load-use stall cycles
module forward_unit_gen #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     IdValid,
    input  logic [NSRC*ADDR_W-1:0]   IdRs,
    input  logic [ADDR_W-1:0]        IdRd,
    input  logic                     IdRegWrite,
    input  logic                     IdMemRead,
    input  logic                     MemWait,
    input  logic                     Flush,
    output logic [2*NSRC-1:0]        Forward,
    output logic                     Stall,
    output logic [CNT_W-1:0]         StallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                   idex_valid;
    logic [NSRC*ADDR_W-1:0] idex_rs;
    logic [ADDR_W-1:0]      idex_rd;
    logic                   idex_regwrite;
    logic                   idex_memread;

    logic                   exmem_valid;
    logic [ADDR_W-1:0]      exmem_rd;
    logic                   exmem_regwrite;

    logic                   memwb_valid;
    logic [ADDR_W-1:0]      memwb_rd;
    logic                   memwb_regwrite;

    logic exmem_prod;
    logic memwb_prod;
    logic rs_match;
    logic hazard;

    // x0 is hardwired, so a write to it never produces a value to forward.
    assign exmem_prod = exmem_valid & exmem_regwrite & (exmem_rd != '0);
    assign memwb_prod = memwb_valid & memwb_regwrite & (memwb_rd != '0);

    // EXMEM is checked first so the youngest producer wins.
    always_comb begin
        Forward = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (idex_valid) begin
                if (exmem_prod &&
                    idex_rs[k*ADDR_W +: ADDR_W] == exmem_rd) begin
                    Forward[2*k +: 2] = 2'b01;
                end else if (memwb_prod &&
                    idex_rs[k*ADDR_W +: ADDR_W] == memwb_rd) begin
                    Forward[2*k +: 2] = 2'b10;
                end
            end
        end
    end

    always_comb begin
        rs_match = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (IdRs[k*ADDR_W +: ADDR_W] == idex_rd) begin
                rs_match = 1'b1;
            end
        end
    end

    // Only the load sitting in IDEX can cause a stall; once it reaches
    // EXMEM its data is one cycle from MEMWB forwarding.
    assign hazard = IdValid & idex_valid & idex_memread & idex_regwrite &
                    (idex_rd != '0) & rs_match;
    assign Stall  = hazard & ~Flush;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            idex_valid     <= 1'b0;
            idex_rs        <= '0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_valid    <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            memwb_valid    <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
            StallCount     <= '0;
        end else if (!MemWait) begin
            memwb_valid    <= exmem_valid;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
            exmem_valid    <= idex_valid;
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            idex_rs        <= IdRs;
            idex_rd        <= IdRd;
            if (Stall || Flush) begin
                idex_valid    <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end else begin
                idex_valid    <= IdValid;
                idex_regwrite <= IdRegWrite;
                idex_memread  <= IdMemRead;
            end
            if (Stall && StallCount != CNT_MAX) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forward_unit_gen.sv
// Scoreboard bench for forward_unit_gen with directed pipeline sequences.
// Two instances share stimulus: default CNT_W and CNT_W=2 for saturation.
module tb_forward_unit_gen;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              id_valid;
    logic [NS*AW-1:0]  id_rs;
    logic [AW-1:0]     id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              mem_wait;
    logic              flush;
    logic [2*NS-1:0]   fwd;
    logic [2*NS-1:0]   fwd2;
    logic              stall;
    logic              stall2;
    logic [CW-1:0]     cnt;
    logic [1:0]        cnt2;

    forward_unit_gen #(.ADDR_W(AW), .NSRC(NS), .CNT_W(CW)) dut (
        .Clk(clk), .Rst(rst), .IdValid(id_valid), .IdRs(id_rs),
        .IdRd(id_rd), .IdRegWrite(id_regwrite), .IdMemRead(id_memread),
        .MemWait(mem_wait), .Flush(flush), .Forward(fwd),
        .Stall(stall), .StallCount(cnt)
    );

    forward_unit_gen #(.ADDR_W(AW), .NSRC(NS), .CNT_W(2)) dut2 (
        .Clk(clk), .Rst(rst), .IdValid(id_valid), .IdRs(id_rs),
        .IdRd(id_rd), .IdRegWrite(id_regwrite), .IdMemRead(id_memread),
        .MemWait(mem_wait), .Flush(flush), .Forward(fwd2),
        .Stall(stall2), .StallCount(cnt2)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        string      name;
        logic [3:0] fwd;
        logic       stall;
        logic [15:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic instr_t alu(input int rd, input int r1, input int r2);
        alu = '{1'b1, 5'(r1), 5'(r2), 5'(rd), 1'b1, 1'b0};
    endfunction

    function automatic instr_t lw(input int rd, input int r1);
        lw = '{1'b1, 5'(r1), 5'd0, 5'(rd), 1'b1, 1'b1};
    endfunction

    function automatic instr_t idle();
        idle = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    endfunction

    function automatic instr_t nop();
        nop = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    endfunction

    // One pipeline cycle: drive ID and controls, optionally queue the
    // expected combinational outputs for this cycle, then cross the edge.
    task automatic step(input instr_t ins, input logic r, input logic mw,
                        input logic fl, input bit chk, input string nm,
                        input logic [3:0] ef, input logic es, input int ec);
        exp_t e;
        rst         = r;
        mem_wait    = mw;
        flush       = fl;
        id_valid    = ins.v;
        id_rs       = {ins.r2, ins.r1};
        id_rd       = ins.rd;
        id_regwrite = ins.rw;
        id_memread  = ins.mr;
        if (chk) begin
            e.name  = nm;
            e.fwd   = ef;
            e.stall = es;
            e.cnt   = 16'(ec);
            e.cnt2  = (ec > 3) ? 2'd3 : 2'(ec);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (fwd !== e.fwd || fwd2 !== e.fwd || stall !== e.stall ||
                stall2 !== e.stall || cnt !== e.cnt || cnt2 !== e.cnt2) begin
                errors++;
                $display("FAIL %s: got fwd=%b/%b stall=%b/%b cnt=%0d/%0d, want fwd=%b stall=%b cnt=%0d/%0d",
                         e.name, fwd, fwd2, stall, stall2, cnt, cnt2,
                         e.fwd, e.stall, e.cnt, e.cnt2);
            end
        end
    end

    initial begin
        int c;
        step(idle(), 1, 0, 0, 0, "", 4'b0, 0, 0);
        step(idle(), 1, 0, 0, 1, "reset", 4'b0000, 0, 0);

        step(alu(5, 1, 2), 0, 0, 0, 1, "add_id", 4'b0000, 0, 0);
        step(alu(6, 5, 3), 0, 0, 0, 1, "add_ex", 4'b0000, 0, 0);
        step(idle(), 0, 0, 0, 1, "raw_exmem", 4'b0001, 0, 0);
        step(idle(), 0, 0, 0, 1, "drain", 4'b0000, 0, 0);

        step(alu(5, 1, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(nop(), 0, 0, 0, 1, "nop_gap", 4'b0000, 0, 0);
        step(alu(8, 4, 5), 0, 0, 0, 1, "nop_ex", 4'b0000, 0, 0);
        step(idle(), 0, 0, 0, 1, "raw_memwb", 4'b1000, 0, 0);

        step(alu(5, 1, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(alu(5, 1, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(alu(9, 5, 5), 0, 0, 0, 1, "dbl_add", 4'b0000, 0, 0);
        step(idle(), 0, 0, 0, 1, "exmem_prio", 4'b0101, 0, 0);

        step(lw(7, 2), 0, 0, 0, 1, "lw_id", 4'b0000, 0, 0);
        step(alu(10, 7, 3), 0, 0, 0, 1, "lu_stall", 4'b0000, 1, 0);
        step(alu(10, 7, 3), 0, 0, 0, 1, "lu_once", 4'b0000, 0, 1);
        step(idle(), 0, 0, 0, 1, "lu_fwd", 4'b0010, 0, 1);

        step(lw(7, 2), 0, 0, 0, 1, "lw_id2", 4'b0000, 0, 1);
        step(alu(10, 7, 3), 0, 0, 1, 1, "flush_prio", 4'b0000, 0, 1);
        step(idle(), 0, 0, 0, 1, "flush_bubble", 4'b0000, 0, 1);

        step(alu(5, 1, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(alu(6, 5, 3), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(idle(), 0, 1, 0, 1, "mw1", 4'b0001, 0, 1);
        step(idle(), 0, 1, 0, 1, "mw2", 4'b0001, 0, 1);
        step(idle(), 0, 1, 0, 1, "mw3", 4'b0001, 0, 1);
        step(idle(), 0, 0, 0, 1, "mw_release", 4'b0001, 0, 1);
        step(idle(), 0, 0, 0, 1, "mw_moved", 4'b0000, 0, 1);

        step(alu(0, 1, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(lw(0, 2), 0, 0, 0, 1, "x0_lw_id", 4'b0000, 0, 1);
        step(alu(0, 0, 0), 0, 0, 0, 1, "x0_nostall", 4'b0000, 0, 1);
        step(alu(11, 0, 0), 0, 0, 0, 1, "x0_nofwd", 4'b0000, 0, 1);
        step(idle(), 0, 0, 0, 1, "x0_nofwd2", 4'b0000, 0, 1);

        step(lw(7, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(lw(7, 2), 0, 0, 0, 1, "ld_ld_nostall", 4'b0000, 0, 1);
        step(alu(10, 7, 3), 0, 1, 0, 1, "stall_mw", 4'b0000, 1, 1);
        step(alu(10, 7, 3), 0, 0, 0, 1, "stall_mw_hold", 4'b0000, 1, 1);
        step(alu(10, 7, 3), 0, 0, 0, 1, "ld_ld_bubble", 4'b0000, 0, 2);
        step(idle(), 0, 0, 0, 1, "ld_ld_fwd", 4'b0010, 0, 2);

        c = 2;
        for (int i = 0; i < 3; i++) begin
            step(lw(7, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
            step(alu(10, 7, 3), 0, 0, 0, 1, "sat_stall", 4'b0000, 1, c);
            c++;
            step(alu(10, 7, 3), 0, 0, 0, 1, "sat_count", 4'b0000, 0, c);
        end
        step(idle(), 0, 0, 0, 1, "sat_final", 4'b0010, 0, 5);

        step(lw(7, 2), 0, 0, 0, 0, "", 4'b0, 0, 0);
        step(alu(10, 7, 3), 1, 1, 0, 1, "rst_mid_stall", 4'b0000, 1, 5);
        step(alu(10, 7, 3), 0, 0, 0, 1, "rst_clear", 4'b0000, 0, 0);
        step(idle(), 0, 0, 0, 0, "", 4'b0, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
